// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the instruction-fetch and data ports.
// Data wins by default, a starvation counter forces the fetch port through, a data-side
// lock holds the memory across atomic sequences and a watchdog aborts hung transactions.
module mem_port_arbiter #(
    parameter int unsigned MAX_STARVE = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        async_rst_n,
    input  logic        clk_en,
    input  logic        i_req,
    input  logic [29:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [29:0] d_addr,
    input  logic [3:0]  d_mask,
    input  logic [31:0] d_wdata,
    input  logic        d_lock,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_we,
    output logic [29:0] m_addr,
    output logic [3:0]  m_mask,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        timeout_err
);

    localparam logic [3:0] STARVE_MAX = 4'(MAX_STARVE);
    localparam logic [7:0] WDOG_LAST  = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StBusyI, StBusyD, StLocked} state_e;

    state_e     state;
    logic [3:0] starve_cnt;
    logic [7:0] wdog_cnt;

    logic busy;
    logic mem_done;
    logic wdog_hit;
    logic xfer_end;
    logic i_starved;
    logic grant_i;
    logic grant_d;

    // Completion decode; a real memory ack wins over a watchdog expiry in the same cycle.
    always_comb begin
        busy     = (state == StBusyI) || (state == StBusyD);
        mem_done = clk_en && busy && m_ack;
        wdog_hit = clk_en && busy && !m_ack && (wdog_cnt == WDOG_LAST);
        xfer_end = mem_done || wdog_hit;
        i_ack    = xfer_end && (state == StBusyI);
        d_ack    = xfer_end && (state == StBusyD);
        i_rdata  = (mem_done && (state == StBusyI)) ? m_rdata : 32'h0;
        d_rdata  = (mem_done && (state == StBusyD)) ? m_rdata : 32'h0;
    end

    // Grant decision; under lock the fetch port is ignored entirely.
    always_comb begin
        i_starved = i_req && (starve_cnt == STARVE_MAX);
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        unique case (state)
            StIdle: begin
                grant_i = i_req && (i_starved || !d_req);
                grant_d = d_req && !i_starved;
            end
            StLocked: grant_d = d_req;
            default: ;
        endcase
    end

    // Arbiter FSM with registered memory-side outputs and bookkeeping counters.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state       <= StIdle;
            m_req       <= 1'b0;
            m_we        <= 1'b0;
            m_addr      <= 30'h0;
            m_mask      <= 4'h0;
            m_wdata     <= 32'h0;
            timeout_err <= 1'b0;
            starve_cnt  <= 4'h0;
            wdog_cnt    <= 8'h0;
        end else if (clk_en) begin
            unique case (state)
                StIdle, StLocked: begin
                    if (grant_i) begin
                        state    <= StBusyI;
                        m_req    <= 1'b1;
                        m_we     <= 1'b0;
                        m_addr   <= i_addr;
                        m_mask   <= 4'hF;
                        m_wdata  <= 32'h0;
                        wdog_cnt <= 8'h0;
                    end else if (grant_d) begin
                        state    <= StBusyD;
                        m_req    <= 1'b1;
                        m_we     <= d_we;
                        m_addr   <= d_addr;
                        m_mask   <= d_mask;
                        m_wdata  <= d_wdata;
                        wdog_cnt <= 8'h0;
                    end else if ((state == StLocked) && !d_lock) begin
                        state <= StIdle;
                    end
                    // Starvation is only tracked in StIdle; grants under lock leave it alone.
                    if (state == StIdle) begin
                        if (!i_req || grant_i) begin
                            starve_cnt <= 4'h0;
                        end else if (grant_d && (starve_cnt != STARVE_MAX)) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                    end
                end
                StBusyI, StBusyD: begin
                    if (xfer_end) begin
                        m_req    <= 1'b0;
                        wdog_cnt <= 8'h0;
                        if (wdog_hit) begin
                            timeout_err <= 1'b1;
                            state       <= StIdle;
                        end else if ((state == StBusyD) && d_lock) begin
                            state <= StLocked;
                        end else begin
                            state <= StIdle;
                        end
                    end else begin
                        wdog_cnt <= wdog_cnt + 8'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of the arbitration rules and a memory array.
module tb_mem_port_arbiter;

    localparam int unsigned MAX_STARVE = 4;
    localparam int unsigned TIMEOUT    = 8;

    logic        clk;
    logic        async_rst_n;
    logic        clk_en;
    logic        i_req;
    logic [29:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [29:0] d_addr;
    logic [3:0]  d_mask;
    logic [31:0] d_wdata;
    logic        d_lock;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_we;
    logic [29:0] m_addr;
    logic [3:0]  m_mask;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;
    logic        timeout_err;

    int total;
    int bad;

    mem_port_arbiter #(
        .MAX_STARVE(MAX_STARVE),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk        (clk),
        .async_rst_n(async_rst_n),
        .clk_en     (clk_en),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_ack      (i_ack),
        .i_rdata    (i_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_mask     (d_mask),
        .d_wdata    (d_wdata),
        .d_lock     (d_lock),
        .d_ack      (d_ack),
        .d_rdata    (d_rdata),
        .m_req      (m_req),
        .m_we       (m_we),
        .m_addr     (m_addr),
        .m_mask     (m_mask),
        .m_wdata    (m_wdata),
        .m_rdata    (m_rdata),
        .m_ack      (m_ack),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid_cycle();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        i_req   = 1'b0;
        i_addr  = 30'h0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = 30'h0;
        d_mask  = 4'h0;
        d_wdata = 32'h0;
        d_lock  = 1'b0;
        m_rdata = 32'h0;
        m_ack   = 1'b0;
    endtask

    task automatic test_reset();
        async_rst_n = 1'b0;
        clk_en      = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        mid_cycle();
        total++;
        if ({m_req, m_we, m_addr, m_mask, m_wdata} !== '0) begin
            bad++;
            $display("FAIL reset_mem_side: got req=%b we=%b addr=%h mask=%h wdata=%h want all 0",
                     m_req, m_we, m_addr, m_mask, m_wdata);
        end
        total++;
        if ({i_ack, d_ack, timeout_err} !== 3'b000) begin
            bad++;
            $display("FAIL reset_acks: got i_ack=%b d_ack=%b terr=%b want 0", i_ack, d_ack,
                     timeout_err);
        end
        async_rst_n = 1'b1;
        next_cycle();
        mid_cycle();
        total++;
        if (m_req !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle_no_req: got m_req=%b want 0", m_req);
        end
    endtask

    task automatic test_single_read();
        next_cycle();
        i_req  = 1'b1;
        i_addr = 30'h10;
        mid_cycle();
        total++;
        if (m_req !== 1'b0) begin
            bad++;
            $display("FAIL single_latency: got m_req=%b in request cycle want 0", m_req);
        end
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            if (c == 3) begin
                m_ack   = 1'b1;
                m_rdata = 32'hDEADBEEF;
            end
            mid_cycle();
            total++;
            if ({m_req, m_we, m_mask, m_addr} !== {1'b1, 1'b0, 4'hF, 30'h10}) begin
                bad++;
                $display("FAIL single_mem_side c%0d: got req=%b we=%b mask=%h addr=%h want 1 0 f 10",
                         c, m_req, m_we, m_mask, m_addr);
            end
            total++;
            if (i_ack !== (c == 3)) begin
                bad++;
                $display("FAIL single_ack c%0d: got i_ack=%b want %b", c, i_ack, (c == 3));
            end
        end
        total++;
        if (i_rdata !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL single_rdata: got %h want deadbeef", i_rdata);
        end
        next_cycle();
        m_ack   = 1'b0;
        m_rdata = 32'h0;
        i_req   = 1'b0;
        mid_cycle();
        total++;
        if ({m_req, i_ack} !== 2'b00) begin
            bad++;
            $display("FAIL single_release: got m_req=%b i_ack=%b want 0 0", m_req, i_ack);
        end
    endtask

    task automatic test_simultaneous();
        next_cycle();
        i_req   = 1'b1;
        i_addr  = 30'h30;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 30'h20;
        d_mask  = 4'h3;
        d_wdata = 32'h1234;
        mid_cycle();
        next_cycle();
        mid_cycle();
        total++;
        if ({m_req, m_we, m_mask, m_addr, m_wdata} !== {1'b1, 1'b1, 4'h3, 30'h20, 32'h1234}) begin
            bad++;
            $display("FAIL simul_d_first: got req=%b we=%b mask=%h addr=%h wdata=%h want 1 1 3 20 1234",
                     m_req, m_we, m_mask, m_addr, m_wdata);
        end
        next_cycle();
        m_ack = 1'b1;
        mid_cycle();
        total++;
        if ({d_ack, i_ack} !== 2'b10) begin
            bad++;
            $display("FAIL simul_d_ack: got d_ack=%b i_ack=%b want 1 0", d_ack, i_ack);
        end
        next_cycle();
        m_ack = 1'b0;
        d_req = 1'b0;
        d_we  = 1'b0;
        mid_cycle();
        total++;
        if (m_req !== 1'b0) begin
            bad++;
            $display("FAIL simul_bubble: got m_req=%b want 0", m_req);
        end
        next_cycle();
        mid_cycle();
        total++;
        if ({m_req, m_we, m_mask, m_addr} !== {1'b1, 1'b0, 4'hF, 30'h30}) begin
            bad++;
            $display("FAIL simul_i_second: got req=%b we=%b mask=%h addr=%h want 1 0 f 30",
                     m_req, m_we, m_mask, m_addr);
        end
        next_cycle();
        m_ack   = 1'b1;
        m_rdata = 32'h5555AAAA;
        mid_cycle();
        total++;
        if ({i_ack, i_rdata} !== {1'b1, 32'h5555AAAA}) begin
            bad++;
            $display("FAIL simul_i_ack: got ack=%b data=%h want 1 5555aaaa", i_ack, i_rdata);
        end
        next_cycle();
        idle_inputs();
        mid_cycle();
    endtask

    task automatic test_starvation();
        int   d_grants;
        bit   i_seen;
        logic prev_m_req;
        d_grants = 0;
        i_seen   = 1'b0;
        next_cycle();
        i_req   = 1'b1;
        i_addr  = 30'h5;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 30'h9;
        d_mask  = 4'hF;
        d_wdata = 32'hA0A0A0A0;
        mid_cycle();
        prev_m_req = m_req;
        for (int c = 0; c < 60 && !i_seen; c++) begin
            next_cycle();
            m_ack = m_req;
            mid_cycle();
            if (m_req && !prev_m_req) begin
                if (m_we) begin
                    d_grants++;
                end else begin
                    i_seen = 1'b1;
                    total++;
                    if (i_ack !== 1'b1) begin
                        bad++;
                        $display("FAIL starve_i_ack: got %b want 1", i_ack);
                    end
                    total++;
                    if (dut.starve_cnt !== 4'h0) begin
                        bad++;
                        $display("FAIL starve_cnt_clear: got %0d want 0", dut.starve_cnt);
                    end
                end
            end
            prev_m_req = m_req;
        end
        total++;
        if (!i_seen || d_grants != MAX_STARVE) begin
            bad++;
            $display("FAIL starve_d_grants: got i_seen=%0d d_grants=%0d want 1 %0d", i_seen,
                     d_grants, MAX_STARVE);
        end
        next_cycle();
        idle_inputs();
        mid_cycle();
        next_cycle();
        mid_cycle();
    endtask

    task automatic test_lock();
        int   d_done;
        int   i_grants;
        logic prev_m_req;
        d_done   = 0;
        i_grants = 0;
        next_cycle();
        i_req   = 1'b1;
        i_addr  = 30'h11;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_lock  = 1'b1;
        d_addr  = 30'h40;
        d_mask  = 4'hF;
        d_wdata = 32'h11112222;
        mid_cycle();
        prev_m_req = m_req;
        for (int c = 0; c < 30 && d_done < 2; c++) begin
            next_cycle();
            d_addr = 30'h40 + 30'(d_done);
            m_ack  = m_req;
            mid_cycle();
            if (m_req && !prev_m_req && !m_we) i_grants++;
            if (d_ack) d_done++;
            prev_m_req = m_req;
        end
        total++;
        if (d_done != 2 || i_grants != 0) begin
            bad++;
            $display("FAIL lock_sequence: got d_done=%0d i_grants=%0d want 2 0", d_done, i_grants);
        end
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            m_ack = 1'b0;
            d_req = 1'b0;
            mid_cycle();
            total++;
            if (m_req !== 1'b0) begin
                bad++;
                $display("FAIL lock_hold c%0d: got m_req=%b want 0", c, m_req);
            end
        end
        next_cycle();
        d_lock = 1'b0;
        mid_cycle();
        next_cycle();
        mid_cycle();
        total++;
        if (m_req !== 1'b0) begin
            bad++;
            $display("FAIL lock_release_idle: got m_req=%b want 0", m_req);
        end
        next_cycle();
        mid_cycle();
        total++;
        if ({m_req, m_we, m_addr} !== {1'b1, 1'b0, 30'h11}) begin
            bad++;
            $display("FAIL lock_i_grant: got req=%b we=%b addr=%h want 1 0 11", m_req, m_we, m_addr);
        end
        next_cycle();
        m_ack = 1'b1;
        mid_cycle();
        next_cycle();
        idle_inputs();
        mid_cycle();
    endtask

    task automatic test_watchdog();
        next_cycle();
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 30'h7;
        d_mask  = 4'hF;
        m_rdata = 32'hFFFFFFFF;
        mid_cycle();
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            mid_cycle();
            total++;
            if (d_ack !== (c == 8)) begin
                bad++;
                $display("FAIL wdog_ack c%0d: got d_ack=%b want %b", c, d_ack, (c == 8));
            end
        end
        total++;
        if (d_rdata !== 32'h0) begin
            bad++;
            $display("FAIL wdog_rdata: got %h want 0", d_rdata);
        end
        next_cycle();
        d_req = 1'b0;
        mid_cycle();
        total++;
        if ({m_req, timeout_err} !== 2'b01) begin
            bad++;
            $display("FAIL wdog_abort: got m_req=%b terr=%b want 0 1", m_req, timeout_err);
        end
        next_cycle();
        i_req   = 1'b1;
        i_addr  = 30'h3;
        m_rdata = 32'h0;
        mid_cycle();
        next_cycle();
        mid_cycle();
        next_cycle();
        m_ack   = 1'b1;
        m_rdata = 32'h0BADF00D;
        mid_cycle();
        total++;
        if ({i_ack, i_rdata, timeout_err} !== {1'b1, 32'h0BADF00D, 1'b1}) begin
            bad++;
            $display("FAIL wdog_recover: got ack=%b data=%h terr=%b want 1 0badf00d 1", i_ack,
                     i_rdata, timeout_err);
        end
        next_cycle();
        idle_inputs();
        mid_cycle();
    endtask

    task automatic test_clk_en();
        next_cycle();
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 30'h2A;
        d_mask = 4'hF;
        mid_cycle();
        next_cycle();
        mid_cycle();
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            clk_en  = 1'b0;
            m_ack   = ((c % 2) == 0);
            m_rdata = 32'h12345678;
            mid_cycle();
            total++;
            if ({d_ack, m_req, m_addr} !== {1'b0, 1'b1, 30'h2A}) begin
                bad++;
                $display("FAIL clken_hold c%0d: got ack=%b req=%b addr=%h want 0 1 2a", c, d_ack,
                         m_req, m_addr);
            end
        end
        next_cycle();
        clk_en  = 1'b1;
        m_ack   = 1'b1;
        m_rdata = 32'hCAFE0001;
        mid_cycle();
        total++;
        if (dut.wdog_cnt !== 8'd1) begin
            bad++;
            $display("FAIL clken_wdog_held: got %0d want 1", dut.wdog_cnt);
        end
        total++;
        if ({d_ack, d_rdata} !== {1'b1, 32'hCAFE0001}) begin
            bad++;
            $display("FAIL clken_resume: got ack=%b data=%h want 1 cafe0001", d_ack, d_rdata);
        end
        next_cycle();
        idle_inputs();
        mid_cycle();
    endtask

    task automatic test_async_reset();
        next_cycle();
        i_req  = 1'b1;
        i_addr = 30'h1F;
        mid_cycle();
        next_cycle();
        m_ack   = 1'b1;
        m_rdata = 32'h77777777;
        mid_cycle();
        total++;
        if ({m_req, i_ack} !== 2'b11) begin
            bad++;
            $display("FAIL arst_pre: got m_req=%b i_ack=%b want 1 1", m_req, i_ack);
        end
        #2;
        async_rst_n = 1'b0;
        #1;
        total++;
        if ({m_req, i_ack, i_rdata, m_addr, m_mask, timeout_err} !== '0) begin
            bad++;
            $display("FAIL arst_immediate: got req=%b ack=%b data=%h addr=%h mask=%h terr=%b want 0",
                     m_req, i_ack, i_rdata, m_addr, m_mask, timeout_err);
        end
        idle_inputs();
        mid_cycle();
        async_rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            mid_cycle();
            total++;
            if ({m_req, i_ack, d_ack} !== 3'b000) begin
                bad++;
                $display("FAIL arst_discard c%0d: got req=%b i_ack=%b d_ack=%b want 0", c, m_req,
                         i_ack, d_ack);
            end
        end
    endtask

    // Random traffic; the bench is the memory and predicts winners from the priority rules:
    // I wins if it has waited through MAX_STARVE data grants or data is not pending.
    task automatic test_random();
        logic [31:0] mem [16];
        logic        prev_i;
        logic        prev_d;
        logic        prev_m_req;
        logic        exp_i;
        bit          i_done;
        bit          d_done;
        bit          mem_active;
        bit          ack_now;
        int          streak;
        int          owner;
        int          dly;
        for (int k = 0; k < 16; k++) mem[k] = $urandom;
        streak     = 0;
        owner      = 0;
        dly        = 0;
        i_done     = 1'b0;
        d_done     = 1'b0;
        mem_active = 1'b0;
        mid_cycle();
        prev_m_req = m_req;
        prev_i     = i_req;
        prev_d     = d_req;
        for (int c = 0; c < 1500; c++) begin
            next_cycle();
            if (i_done) i_req = 1'b0;
            if (d_done) d_req = 1'b0;
            i_done = 1'b0;
            d_done = 1'b0;
            if (!i_req && $urandom_range(0, 3) == 0) begin
                i_req  = 1'b1;
                i_addr = 30'($urandom_range(0, 15));
                streak = 0;
            end
            if (!d_req && $urandom_range(0, 2) != 0) begin
                d_req   = 1'b1;
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = 30'($urandom_range(0, 15));
                d_mask  = 4'($urandom_range(0, 15));
                d_wdata = $urandom;
            end
            ack_now = 1'b0;
            m_ack   = 1'b0;
            if (m_req && !mem_active) begin
                mem_active = 1'b1;
                dly        = $urandom_range(0, 4);
            end
            if (mem_active) begin
                if (dly == 0) begin
                    ack_now    = 1'b1;
                    mem_active = 1'b0;
                    m_ack      = 1'b1;
                    m_rdata    = m_we ? $urandom : mem[m_addr[3:0]];
                end else begin
                    dly--;
                end
            end
            mid_cycle();
            if (!prev_m_req) begin
                total++;
                if (m_req !== (prev_i || prev_d)) begin
                    bad++;
                    $display("FAIL rnd_grant c%0d: got m_req=%b want %b", c, m_req,
                             (prev_i || prev_d));
                end
                if (m_req) begin
                    exp_i = prev_i && ((streak >= int'(MAX_STARVE)) || !prev_d);
                    owner = exp_i ? 1 : 2;
                    total++;
                    if (exp_i) begin
                        if ({m_we, m_mask, m_addr} !== {1'b0, 4'hF, i_addr}) begin
                            bad++;
                            $display("FAIL rnd_i_winner c%0d: got we=%b mask=%h addr=%h want 0 f %h",
                                     c, m_we, m_mask, m_addr, i_addr);
                        end
                        streak = 0;
                    end else begin
                        if ({m_we, m_mask, m_addr, m_wdata} !== {d_we, d_mask, d_addr, d_wdata}) begin
                            bad++;
                            $display("FAIL rnd_d_winner c%0d: got we=%b mask=%h addr=%h wd=%h want %b %h %h %h",
                                     c, m_we, m_mask, m_addr, m_wdata, d_we, d_mask, d_addr, d_wdata);
                        end
                        if (prev_i) streak++;
                    end
                end
            end
            total++;
            if (ack_now) begin
                if ({i_ack, d_ack} !== {owner == 1, owner == 2}) begin
                    bad++;
                    $display("FAIL rnd_ack_route c%0d: got i=%b d=%b want owner %0d", c, i_ack,
                             d_ack, owner);
                end
                if (owner == 1) begin
                    total++;
                    if (i_rdata !== mem[i_addr[3:0]]) begin
                        bad++;
                        $display("FAIL rnd_i_data c%0d: got %h want %h", c, i_rdata,
                                 mem[i_addr[3:0]]);
                    end
                    i_done = 1'b1;
                end else if (owner == 2) begin
                    if (!d_we) begin
                        total++;
                        if (d_rdata !== mem[d_addr[3:0]]) begin
                            bad++;
                            $display("FAIL rnd_d_data c%0d: got %h want %h", c, d_rdata,
                                     mem[d_addr[3:0]]);
                        end
                    end else begin
                        for (int b = 0; b < 4; b++) begin
                            if (d_mask[b]) mem[d_addr[3:0]][8*b +: 8] = d_wdata[8*b +: 8];
                        end
                    end
                    d_done = 1'b1;
                end
                owner = 0;
            end else if ({i_ack, d_ack} !== 2'b00) begin
                bad++;
                $display("FAIL rnd_spurious_ack c%0d: got i=%b d=%b want 0 0", c, i_ack, d_ack);
            end
            prev_m_req = m_req;
            prev_i     = i_req;
            prev_d     = d_req;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single_read();
        test_simultaneous();
        test_starvation();
        test_lock();
        test_watchdog();
        test_clk_en();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified single-ported memory between the core's instruction-fetch port and data port.
- Arbitration is registered:
  - data port has priority by default;
  - an instruction-starvation guard overrides that priority;
  - a data-side bus lock holds the memory for atomic sequences;
  - a watchdog aborts hung memory transactions.
- Sits between the core's fetch/data interfaces and the memory/bus fabric.

Parameters:
- MAX_STARVE, 4: consecutive data grants allowed while i_req is pending before the instruction port is forced to win (range 1..15).
- TIMEOUT, 64: cycles in a BUSY state without m_ack before the transaction is aborted (range 2..255).

Ports:
- clk  in  1  core clock.
- async_rst_n  in  1  asynchronous active-low reset.
- clk_en  in  1  global clock enable; all registers hold when low.
- i_req  in  1  instruction read request; held until i_ack.
- i_addr  in  30  instruction word address.
- i_ack  out  1  instruction transaction complete.
- i_rdata  out  32  instruction read data, valid with i_ack.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  30  data word address.
- d_mask  in  4  byte enables.
- d_wdata  in  32  write data.
- d_lock  in  1  bus lock request (atomic sequence).
- d_ack  out  1  data transaction complete.
- d_rdata  out  32  data read data, valid with d_ack.
- m_req  out  1  memory request.
- m_we  out  1  memory write enable.
- m_addr  out  30  memory word address.
- m_mask  out  4  memory byte enables.
- m_wdata  out  32  memory write data.
- m_rdata  in  32  memory read data.
- m_ack  in  1  memory completion, 1-cycle pulse.
- timeout_err  out  1  sticky watchdog error flag.

Behaviour:
- Reset (async, active-low):
  - state = IDLE;
  - m_req, m_we, m_addr, m_mask, m_wdata, timeout_err, starve_cnt, wdog_cnt all 0;
  - i_ack = d_ack = 0.
- States: IDLE, BUSY_I, BUSY_D, LOCKED. All transitions are qualified by clk_en = 1.
- IDLE arbitration, evaluated each enabled cycle:
  - starve_cnt == MAX_STARVE and i_req: grant I.
  - else d_req: grant D.
  - else i_req: grant I.
  - else stay in IDLE.
- On a grant:
  - capture the winner's address/mask/wdata/we into the m_* registers (instruction grants force m_we = 0 and m_mask = 4'hF);
  - set m_req = 1 next cycle;
  - enter BUSY_I or BUSY_D.
- Latency: request visible in cycle N → m_req high in cycle N+1.
- BUSY_x:
  - m_* are stable and wdog_cnt increments each cycle.
  - On m_ack & clk_en:
    - x_ack = 1 in the same cycle (combinational);
    - x_rdata = m_rdata (combinational passthrough);
    - m_req drops next cycle;
    - wdog_cnt is cleared.
  - Next state after m_ack: from BUSY_D with d_lock = 1, go to LOCKED; otherwise go to IDLE.
  - Back-to-back grants therefore have a 1-cycle bubble minimum.
- LOCKED:
  - only the data port can be granted; i_req is ignored.
  - d_req → grant D (BUSY_D);
  - d_lock = 0 and no d_req → IDLE;
  - d_lock = 0 with d_req → grant D; the lock releases after that transaction.
- starve_cnt:
  - +1 (saturating at MAX_STARVE) on each D grant made while i_req = 1;
  - cleared on each I grant and whenever i_req = 0 in IDLE.
  - It is not incremented by grants made in LOCKED; the lock takes precedence.
- Watchdog: when wdog_cnt reaches TIMEOUT-1 in BUSY_x without m_ack:
  - assert x_ack with x_rdata = 0;
  - drop m_req;
  - set timeout_err = 1 (sticky until reset);
  - go to IDLE (lock also dropped).
- Outside BUSY_x: i_ack/d_ack are 0, i_rdata/d_rdata are 0, and m_ack is ignored.
- A request deasserted before its ack is a protocol violation; the arbiter completes the captured transaction regardless.
- clk_en = 0:
  - all registers hold;
  - i_ack and d_ack are forced to 0;
  - m_ack is treated as not seen.
- Reset mid-transaction: m_req drops immediately (async), and the pending transaction is discarded without an ack.

Test Plan:
- Single read: i_req, i_addr = 0x10 at cycle 0; memory acks at cycle 3 with 0xDEADBEEF → m_req high cycles 1–3, m_addr = 0x10, m_we = 0, m_mask = F, i_ack pulse at cycle 3 with i_rdata = 0xDEADBEEF.
- Simultaneous: i_req and d_req (write, addr 0x20, mask 0x3, wdata 0x1234) at cycle 0 → D served first (m_we = 1, m_mask = 3), I granted in the IDLE cycle after d_ack.
- Starvation: i_req held while d_req is continuously reasserted, MAX_STARVE = 4 → exactly 4 D grants, then the I grant, then starve_cnt = 0.
- Lock: d_lock = 1 across two data transactions while i_req is pending → I is never granted until d_lock = 0 and d_req = 0; then I is granted next cycle.
- Watchdog: TIMEOUT = 8, memory never acks a D read → d_ack at cycle 8 after the grant with d_rdata = 0, timeout_err = 1 stays set, and the next request is served normally.
- clk_en/reset: clk_en = 0 for 5 cycles mid-BUSY with m_ack pulsing → no ack and state held; async_rst_n low mid-BUSY → all outputs 0 immediately.
